cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between the execution-unit requesters that complete in the same cycle: integer ALU, load/store, multiplier and divider.
- Grants one requester per cycle under round-robin scheduling and registers the winner's result onto the CDB.
- The registered CDB drives the dispatch unit, Tag_FIFO, Register_Status_Table and RegisterFile write-back.
- Branch resolution also travels on the CDB and is sequenced by this block.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the integer ALU. Legal range is 2..8.
- DATA_WIDTH, 32, result data width.
- TAG_WIDTH, 7, rename tag width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of the in-flight CDB broadcast and of this cycle's grant.
- req_valid  in  NUM_REQ  request i holds a completed result.
- req_tag  in  NUM_REQ*TAG_WIDTH  packed tags; slice i is [i*TAG_WIDTH +: TAG_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed result data.
- req_branch  in  NUM_REQ  result is a branch resolution.
- req_branch_taken  in  NUM_REQ  branch outcome; ignored unless req_branch is 1.
- req_grant  out  NUM_REQ  one-hot combinational grant; the requester retires its result this cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_WIDTH  registered tag.
- cdb_data  out  DATA_WIDTH  registered data.
- cdb_branch  out  1  registered branch flag.
- cdb_branch_taken  out  1  registered branch outcome.
- cdb_src  out  3  index of the requester that owns the current broadcast.
- rr_ptr  out  3  current round-robin start index, exposed for debug and verification.

Behaviour:

Reset (reset=0, asynchronous):
- cdb_valid, cdb_branch and cdb_branch_taken = 0.
- cdb_tag, cdb_data and cdb_src = 0.
- rr_ptr = 0.
- req_grant is forced to 0 for as long as reset is held.
- Reset asserted mid-broadcast drops the broadcast immediately; no replay after release.

Handshake:
- A requester asserts req_valid with stable tag, data and branch fields.
- It holds them unchanged until it sees req_grant[i]=1 at a rising edge.
- Deasserting valid before grant is illegal; the assertion in the bench flags it.
- A new request may be presented in the cycle after a grant.

Arbitration (combinational, cycle t):
- Scan from index rr_ptr upward, modulo NUM_REQ.
- Grant the first i with req_valid[i]=1 and flush=0.
- At most one grant bit is high.
- With no valid request, or with flush=1, req_grant=0.

Latency:
- The payload of the request granted in cycle t appears on the cdb_* outputs in cycle t+1, with cdb_valid=1.
- Each broadcast lasts exactly one cycle.
- If nothing is granted in cycle t, cdb_valid=0 in t+1, and the cdb_tag/cdb_data values are don't-care.

Pointer update on each edge:
- On a grant to index g, rr_ptr <= (g+1) mod NUM_REQ.
- With no grant, rr_ptr holds.
- Wrap-around: a grant to NUM_REQ-1 sets rr_ptr=0.

Fairness:
- With all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Worst-case wait for any pending request is NUM_REQ-1 cycles.

Flush:
- In the cycle flush=1: no grant is issued, and rr_ptr holds.
- Next cycle: cdb_valid=0, which squashes any result that would have broadcast.
- Requesters keep their valid requests; the owning unit must clear them if they are squashed.
- Simultaneous flush with a pending branch result: the branch is not broadcast that cycle.

Branch ordering:
- Branch results get no priority; they arbitrate like any other result.
- cdb_branch_taken is forced to 0 whenever cdb_branch=0.

Bounds:
- Widths are fixed as above; NUM_REQ is limited to 8, so the 3-bit rr_ptr and cdb_src never overflow.
- rr_ptr is always less than NUM_REQ.

Test Plan:
1. Reset: hold reset=0 with all req_valid=1 → req_grant=0, cdb_valid=0, rr_ptr=0. Release reset → the first grant is 4'b0001, and next cycle cdb_tag equals req_tag slice 0.
2. Single request: only req_valid[2]=1 with tag=7'h15, data=32'hDEADBEEF → req_grant=4'b0100 in the same cycle. Next cycle: cdb_valid=1, cdb_tag=7'h15, cdb_data=32'hDEADBEEF, cdb_src=2, rr_ptr=3.
3. Round-robin fairness: all four requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3, and cdb_valid=1 every cycle from cycle 2 on.
4. Wrap-around: rr_ptr=3 with req_valid=4'b1001 → grant index 3, then rr_ptr=0 and the next grant is index 0. With req_valid=4'b0001 and rr_ptr=1 → grant index 0.
5. Flush: req_valid[1]=1 is granted in cycle t and flush=1 in t+1 with req_valid[0]=1 → cdb_valid=1 in t+1 (already registered), no grant in t+1, cdb_valid=0 in t+2, and rr_ptr unchanged through t+1.
6. Branch broadcast plus mid-operation reset: a granted req_branch=1, taken=1 → cdb_branch=1, cdb_branch_taken=1. A granted req_branch=0 with taken=1 → cdb_branch_taken=0. Asserting reset while cdb_valid=1 → cdb_valid drops to 0 asynchronously and rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: picks one completing execution
// unit per cycle and registers its result as a one-cycle CDB broadcast.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_branch,
    input  logic [NUM_REQ-1:0]              req_branch_taken,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic                            cdb_valid,
    output logic [TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]           cdb_data,
    output logic                            cdb_branch,
    output logic                            cdb_branch_taken,
    output logic [2:0]                      cdb_src,
    output logic [2:0]                      rr_ptr
);

    logic [NUM_REQ-1:0]    grant_d;
    logic                  granted_d;
    logic [2:0]            grantIdx_d;
    int unsigned           scanIdx;

    logic [TAG_WIDTH-1:0]  selTag;
    logic [DATA_WIDTH-1:0] selData;
    logic                  selBranch;
    logic                  selTaken;

    logic                  cdb_valid_q;
    logic [TAG_WIDTH-1:0]  cdb_tag_q;
    logic [DATA_WIDTH-1:0] cdb_data_q;
    logic                  cdb_branch_q;
    logic                  cdb_branch_taken_q;
    logic [2:0]            cdb_src_q;
    logic [2:0]            rr_ptr_q;
    logic [2:0]            rr_ptr_d;

    // Scan from the round-robin pointer upward (modulo NUM_REQ); flush and a held
    // reset both suppress the grant so no requester retires its result.
    always_comb begin
        grant_d    = '0;
        granted_d  = 1'b0;
        grantIdx_d = '0;
        scanIdx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = (32'(rr_ptr_q) + 32'(k)) % 32'(NUM_REQ);
            if (!granted_d && req_valid[scanIdx]) begin
                granted_d         = 1'b1;
                grant_d[scanIdx]  = 1'b1;
                grantIdx_d        = 3'(scanIdx);
            end
        end
        if (flush || !reset) begin
            grant_d   = '0;
            granted_d = 1'b0;
        end
    end

    // One-hot grant lets the payload be selected with a plain AND-OR mux.
    always_comb begin
        selTag    = '0;
        selData   = '0;
        selBranch = 1'b0;
        selTaken  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_d[i]) begin
                selTag    = selTag    | req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                selData   = selData   | req_data[i*DATA_WIDTH +: DATA_WIDTH];
                selBranch = selBranch | req_branch[i];
                selTaken  = selTaken  | (req_branch[i] & req_branch_taken[i]);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (granted_d) begin
            rr_ptr_d = (32'(grantIdx_d) == NUM_REQ - 1) ? 3'd0 : grantIdx_d + 3'd1;
        end
    end

    // Tag/data/source hold while idle since they are meaningless without valid;
    // the branch flags clear so a stale outcome never reaches resolution logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid_q        <= 1'b0;
            cdb_tag_q          <= '0;
            cdb_data_q         <= '0;
            cdb_branch_q       <= 1'b0;
            cdb_branch_taken_q <= 1'b0;
            cdb_src_q          <= '0;
            rr_ptr_q           <= '0;
        end else begin
            cdb_valid_q        <= granted_d;
            cdb_branch_q       <= granted_d & selBranch;
            cdb_branch_taken_q <= granted_d & selBranch & selTaken;
            rr_ptr_q           <= rr_ptr_d;
            if (granted_d) begin
                cdb_tag_q  <= selTag;
                cdb_data_q <= selData;
                cdb_src_q  <= grantIdx_d;
            end
        end
    end

    assign req_grant        = grant_d;
    assign cdb_valid        = cdb_valid_q;
    assign cdb_tag          = cdb_tag_q;
    assign cdb_data         = cdb_data_q;
    assign cdb_branch       = cdb_branch_q;
    assign cdb_branch_taken = cdb_branch_taken_q;
    assign cdb_src          = cdb_src_q;
    assign rr_ptr           = rr_ptr_q;

endmodule
